// File: rtl/mmio_pkg.sv
// Shared constants and types for the data-memory / MMIO responder.
// Holds the MMIO window layout, STATUS bit positions, the region-select
// enum used by the address decoder, and a helper that packs STATUS.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam logic [3:0]  TXDATA_OFF = 4'h0;
  localparam logic [3:0]  STATUS_OFF = 4'h4;
  localparam logic [3:0]  CYCLE_OFF  = 4'h8;
  localparam logic [3:0]  DROPS_OFF  = 4'hC;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_COUNT_LSB = 8;

  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;

  function automatic logic [31:0] packStatus(logic [7:0] cnt, logic empty, logic full);
    logic [31:0] s;
    s = '0;
    s[STATUS_COUNT_LSB +: 8] = cnt;
    s[STATUS_EMPTY_BIT]      = empty;
    s[STATUS_FULL_BIT]       = full;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, single clock.
// Ports: clk, reset (sync, active-high), push/din write side,
// pop/dout read side (dout is the head word, 0 when empty),
// full, empty, count (0..DEPTH).
// A push while full is only taken when a pop retires the head on the same
// edge; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr, rdPtr;
  logic             pushEff, popEff;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign popEff  = pop && !empty;
  assign pushEff = push && (!full || popEff);
  // Storage is never reset, so mask the head to keep dout at 0 when empty.
  assign dout    = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushEff) wrPtr <= wrPtr + PW'(1);
      if (popEff)  rdPtr <= rdPtr + PW'(1);
      case ({pushEff, popEff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pushEff) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-memory responder for the CPU memory stage.
// Ports: clk, reset (sync, active-high); A/WD/WE from the CPU, RD back
// combinationally; out_data/out_valid/out_ready stream the TXDATA FIFO
// to an external consumer.
// Map: RAM at [0, 4*RAM_WORDS); MMIO at 0xFFFF000x (TXDATA, STATUS,
// CYCLE, DROPS); everything else reads 0 and ignores writes.
module data_mem_mmio
  import mmio_pkg::*;
#(
  parameter int    RAM_WORDS  = 256,
  parameter int    FIFO_DEPTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   ram [RAM_WORDS];
  region_e       region;
  logic [AW-1:0] ramIdx;
  logic [3:0]    mmioOff;
  logic          mmioWr, txPush, drop;
  logic          fifoFull, fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic [31:0]   cycleCnt, dropCnt, statusWord;
  logic          unusedAddr;

  assign unusedAddr = ^A[1:0];

  always_comb begin
    region = REG_NONE;
    if (A[31:AW+2] == '0)                region = REG_RAM;
    else if (A[31:4] == MMIO_BASE[31:4]) region = REG_MMIO;
  end

  assign ramIdx  = A[AW+1:2];
  assign mmioOff = {A[3:2], 2'b00};

  // MMIO side effects are suppressed in the reset cycle; RAM writes are not.
  assign mmioWr = WE && (region == REG_MMIO) && !reset;
  assign txPush = mmioWr && (mmioOff == TXDATA_OFF);
  // Full implies non-empty, so a pop this edge is exactly out_ready.
  assign drop   = txPush && fifoFull && !out_ready;

  always_ff @(posedge clk) begin
    if (WE && region == REG_RAM) ram[ramIdx] <= WD;
  end

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (txPush),
    .pop   (out_ready),
    .din   (WD),
    .dout  (out_data),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign out_valid = !fifoEmpty;

  always_ff @(posedge clk) begin
    if (reset)                                cycleCnt <= '0;
    else if (mmioWr && mmioOff == CYCLE_OFF)  cycleCnt <= '0;
    else                                      cycleCnt <= cycleCnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)                                dropCnt <= '0;
    else if (mmioWr && mmioOff == DROPS_OFF)  dropCnt <= '0;
    else if (drop && dropCnt != '1)           dropCnt <= dropCnt + 32'd1;
  end

  assign statusWord = packStatus(8'(fifoCount), fifoEmpty, fifoFull);

  always_comb begin
    RD = '0;
    unique case (region)
      REG_RAM: RD = ram[ramIdx];
      REG_MMIO: begin
        case (mmioOff)
          STATUS_OFF: RD = statusWord;
          CYCLE_OFF:  RD = cycleCnt;
          DROPS_OFF:  RD = dropCnt;
          default:    RD = '0;
        endcase
      end
      default: RD = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;

  localparam int DEPTH = 8;
  localparam logic [31:0] TX = 32'hFFFF_0000, ST = 32'hFFFF_0004,
                          CY = 32'hFFFF_0008, DR = 32'hFFFF_000C;

  logic        clk = 0;
  logic        reset, WE, outReady, outValid;
  logic [31:0] A, WD, RD, outData;

  int vectors = 0;
  int miscompares = 0;

  data_mem_mmio #(.RAM_WORDS(256), .FIFO_DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .A(A), .WD(WD), .WE(WE), .RD(RD),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] a, wd;
    logic        we, rdy, chkRd;
    logic [31:0] expRd;
    logic        expValid;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[$];

  // Reference model: plain arrays/queues following the address map rules.
  logic [31:0] ramM [int];
  logic [31:0] q[$];
  logic [31:0] cycM, dropsM;

  task automatic addV(input logic rst, input logic [31:0] a, wd, input logic we, rdy,
                      input logic chkRd, input logic [31:0] expRd,
                      input logic expValid, input logic [31:0] expData);
    vec_t v;
    v.rst = rst; v.a = a; v.wd = wd; v.we = we; v.rdy = rdy; v.chkRd = chkRd;
    v.expRd = expRd; v.expValid = expValid; v.expData = expData;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t A=%h)", name, act, exp, $time, A);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] a, wd, input logic we, rdy);
    reset = r; A = a; WD = wd; WE = we; outReady = rdy;
    #1;
  endtask

  function automatic logic [31:0] modelRd(input logic [31:0] a, output logic known);
    known = 1'b1;
    if (a < 32'h400) begin
      if (ramM.exists(int'(a[9:2]))) return ramM[int'(a[9:2])];
      known = 1'b0;
      return '0;
    end
    if (a[31:4] == 28'hFFFF000) begin
      case (a[3:2])
        2'd1: return {16'b0, 8'(q.size()), 6'b0, q.size() == 0, q.size() == DEPTH};
        2'd2: return cycM;
        2'd3: return dropsM;
        default: return '0;
      endcase
    end
    return '0;
  endfunction

  // Clock edge: advance the model with the inputs currently driven.
  task automatic advance();
    logic isRam, isMmio;
    @(posedge clk);
    isRam  = A < 32'h400;
    isMmio = A[31:4] == 28'hFFFF000;
    if (WE && isRam) ramM[int'(A[9:2])] = WD;
    if (reset) begin
      q.delete(); cycM = 0; dropsM = 0;
    end else begin
      if (q.size() > 0 && outReady) void'(q.pop_front());
      if (WE && isMmio && A[3:2] == 2'd0) begin
        if (q.size() < DEPTH) q.push_back(WD);
        else if (dropsM != 32'hFFFF_FFFF) dropsM++;
      end
      if (WE && isMmio && A[3:2] == 2'd2) cycM = 0; else cycM++;
      if (WE && isMmio && A[3:2] == 2'd3) dropsM = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] e, a;
    logic known;
    cycM = 0; dropsM = 0;

    // Reset with a RAM write in the same cycle; RAM must still take it.
    addV(1, 32'h10, 32'h1111_1111, 1, 0, 0, 0, 0, 0);
    addV(0, 32'h10, 32'hDEAD_BEEF, 1, 0, 1, 32'h1111_1111, 0, 0);  // old value
    addV(0, 32'h10, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    addV(0, 32'h13, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    addV(0, CY, 0, 0, 0, 1, 3, 0, 0);
    addV(0, CY, 0, 0, 0, 1, 4, 0, 0);
    addV(0, CY, 32'h1234, 1, 0, 1, 5, 0, 0);                     // clear
    addV(0, CY, 0, 0, 0, 1, 0, 0, 0);
    addV(0, CY, 0, 0, 0, 1, 1, 0, 0);
    addV(0, 32'h8000_0000, 32'h1234_5678, 1, 0, 1, 0, 0, 0);
    addV(0, 32'h8000_0000, 0, 0, 0, 1, 0, 0, 0);
    addV(0, 32'hFFFF_0010, 32'h77, 1, 0, 1, 0, 0, 0);
    addV(0, 32'h10, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    // RAM top boundary: 0x400 is unmapped and must not alias word 0.
    addV(0, 32'h0, 32'h0A0A_0A0A, 1, 0, 0, 0, 0, 0);
    addV(0, 32'h400, 32'h55, 1, 0, 1, 0, 0, 0);
    addV(0, 32'h0, 0, 0, 0, 1, 32'h0A0A_0A0A, 0, 0);
    addV(0, 32'h3FC, 32'hCAFE_F00D, 1, 0, 0, 0, 0, 0);
    addV(0, 32'h3FF, 0, 0, 0, 1, 32'hCAFE_F00D, 0, 0);
    // Fill, overflow, status.
    for (int k = 1; k <= 8; k++) addV(0, TX, k, 1, 0, 1, 0, k > 1, k > 1 ? 1 : 0);
    addV(0, ST, 0, 0, 0, 1, 32'h0801, 1, 1);
    addV(0, TX, 9, 1, 0, 1, 0, 1, 1);
    addV(0, DR, 0, 0, 0, 1, 1, 1, 1);
    // Full with simultaneous push and pop.
    addV(0, TX, 32'hAA, 1, 1, 1, 0, 1, 1);
    addV(0, ST, 0, 0, 0, 1, 32'h0801, 1, 2);
    addV(0, DR, 0, 0, 0, 1, 1, 1, 2);
    // Drain: STATUS read shows pre-pop state each cycle.
    addV(0, ST, 0, 0, 1, 1, 32'h0801, 1, 2);
    for (int k = 3; k <= 8; k++) addV(0, ST, 0, 0, 1, 1, (10 - k) << 8, 1, k);
    addV(0, ST, 0, 0, 1, 1, 32'h0100, 1, 32'hAA);
    addV(0, ST, 0, 0, 1, 1, 32'h0002, 0, 0);
    // Reset mid-stream; the TXDATA write in the reset cycle is ignored.
    addV(0, TX, 32'h31, 1, 0, 1, 0, 0, 0);
    addV(0, TX, 32'h32, 1, 0, 1, 0, 1, 32'h31);
    addV(0, TX, 32'h33, 1, 0, 1, 0, 1, 32'h31);
    addV(1, TX, 32'h99, 1, 0, 1, 0, 1, 32'h31);
    addV(0, ST, 0, 0, 0, 1, 32'h0002, 0, 0);
    addV(0, CY, 0, 0, 0, 1, 1, 0, 0);
    addV(0, DR, 0, 0, 0, 1, 0, 0, 0);
    addV(0, 32'h10, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].a, vecs[i].wd, vecs[i].we, vecs[i].rdy);
      if (i > 0) begin
        if (vecs[i].chkRd) chk($sformatf("vec%0d RD", i), RD, vecs[i].expRd);
        chk($sformatf("vec%0d out_valid", i), 32'(outValid), 32'(vecs[i].expValid));
        chk($sformatf("vec%0d out_data", i), outData, vecs[i].expData);
      end
      advance();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      else if (sel < 9)  a = 32'hFFFF_0000 | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      else               a = 32'h8000_0000 | $urandom;
      drive($urandom_range(0, 99) == 0, a, $urandom, $urandom_range(0, 1),
            $urandom_range(0, 2) == 0);
      e = modelRd(A, known);
      if (known) chk("rand RD", RD, e);
      chk("rand out_valid", 32'(outValid), 32'(q.size() != 0));
      chk("rand out_data", outData, q.size() != 0 ? q[0] : 32'h0);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
